pool_stream_array: RTL and testbench
====================================

Name: pool_stream_array

Overview:
- Single-clock streaming 2x2/stride-2 pooling engine for array_size parallel channels, all in lockstep.
- Selectable max or average mode per frame.
- Accepts one row-major pixel per channel per handshake and keeps a per-channel half-row line buffer, so no external 4-way demux or FIFOs are needed.
- Sits between the conv/systolic output stage and the next layer's input buffer; emits one pooled value per channel per 2x2 window.

Parameters:
- data_size, 16, signed two's-complement pixel width per channel.
- array_size, 9, number of parallel channels.
- img_width, 8, pixels per input row; must be even and >= 2.
- img_height, 8, rows per input frame; must be even and >= 2.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous frame abort; same effect as reset except line-buffer contents.
- mode  input  1  0 = max, 1 = average; sampled only on the first pixel of a frame.
- in_valid  input  1  data_in holds one pixel for every channel.
- in_ready  output  1  block can accept a pixel this cycle.
- data_in  input  data_size*array_size  channel i at bits [(i+1)*data_size-1 : i*data_size].
- out_valid  output  1  data_out holds a pooled result.
- out_ready  input  1  downstream accepts data_out.
- data_out  output  data_size*array_size  pooled result per channel, same packing as data_in.
- out_last  output  1  high with out_valid for the final window of a frame.
- busy  output  1  frame in progress: first pixel accepted, last result not yet accepted.

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid, out_last, busy = 0; data_out = 0.
  - col and row counters = 0; mode register = 0.
  - in_ready = 1 once rst_n is released.
  - Line buffer is not reset; it is always written before it is read.
- Handshakes:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - in_ready = !out_valid || out_ready (single output register, full throughput with no bubbles).
- Counters:
  - col runs 0..img_width-1; at wrap, row increments.
  - row runs 0..img_height-1; both wrap to 0 after the last pixel of the frame.
  - Counters advance only on an input transfer.
- Mode capture: at a transfer with col=0, row=0, mode is latched into mode_r and used for the whole frame. Changing mode mid-frame has no effect.
- Per-channel datapath, with combine = max(signed) or sum:
  - Even row, even col: hold pixel in reg a.
  - Even row, odd col: lb[col>>1] = combine(a, pix).
  - Odd row, even col: hold pixel in reg b.
  - Odd row, odd col: result = combine(lb[col>>1], combine(b, pix)), registered into data_out.
  - out_valid is set the cycle after this transfer (latency 1 clock).
- Width rules:
  - Average-mode line buffer and pair sums are data_size+1 bits; the 4-sum is data_size+2 bits.
  - Average output = 4-sum arithmetically shifted right by 2 (floor toward -inf), truncated to data_size. Truncation is always lossless.
  - Max compares are signed.
- out_last: set together with out_valid when the registering window is (row=img_height-1, col=img_width-1); cleared when that output transfers.
- busy:
  - Set on the first-pixel transfer.
  - Cleared on the out_last output transfer.
  - A new frame's first pixel may be accepted in the same cycle the last output transfers; busy then stays 1.
- Backpressure: with out_valid=1 and out_ready=0, data_out and out_last stay stable and in_ready=0. No input is accepted, so no result is lost.
- Simultaneous output transfer and window-completing input transfer: the new result overwrites the register and out_valid stays 1.
- clear (synchronous, highest priority over transfers):
  - Counters return to 0; out_valid, out_last, busy = 0.
  - Any pending output is discarded; the next pixel is treated as frame start.
- Reset or clear mid-frame: the partial frame is abandoned and no output is produced for it.
- Results per frame: exactly (img_width/2)*(img_height/2).

Test Plan:
- Max, 4x4 frame, 1 channel of interest, ch0 pixels 0..15 row-major, out_ready=1 -> outputs 5, 7, 13, 15 in order; out_last only with 15; busy drops the cycle after.
- Average, window {-1,-2,-3,-4} on ch0 and {32767,32767,32767,32767} on ch1 -> ch0 = -3 (floor of -10/4 = -2.5); ch1 = 32767, with no overflow.
- Backpressure: hold out_ready=0 for 5 cycles after the first result -> data_out stable, in_ready=0, no counter advance. On release, the next results match the golden model, with no loss or duplication.
- Mode toggled 0->1 mid-frame -> whole frame uses max. The next frame, started with mode=1, yields averages.
- clear asserted after 6 of 16 pixels, then a fresh 4x4 frame of all 9 -> exactly 4 outputs of 9; no residue from the aborted frame.
- Back-to-back frames with in_valid held high and out_ready=1 -> 8 outputs in 32 input transfers, no stall cycles; busy remains 1 across the frame boundary.

Source files
------------

// File: rtl/pool_stream_if.sv
// ---------------------------------------------------------------------------
// pool_stream_if
//   Streaming bus between a pixel producer, the pool_stream_array pooling
//   engine and its downstream consumer.
//
//   Signals
//     mode       0 = max pooling, 1 = average pooling (frame-start sample)
//     in_valid   data_in carries one pixel for every channel
//     in_ready   engine can take a pixel this cycle
//     data_in    channel i at [(i+1)*data_size-1 : i*data_size]
//     out_valid  data_out carries a pooled result
//     out_ready  consumer takes data_out this cycle
//     data_out   pooled result per channel, same packing as data_in
//     out_last   final window of the frame
//
//   Modports
//     master  the side that feeds pixels and consumes results
//     slave   the pooling engine
// ---------------------------------------------------------------------------
interface pool_stream_if #(
  parameter int data_size  = 16,
  parameter int array_size = 9
);

  logic                             mode;
  logic                             in_valid;
  logic                             in_ready;
  logic [data_size*array_size-1:0]  data_in;
  logic                             out_valid;
  logic                             out_ready;
  logic [data_size*array_size-1:0]  data_out;
  logic                             out_last;

  modport master (
    output mode, in_valid, data_in, out_ready,
    input  in_ready, out_valid, data_out, out_last
  );

  modport slave (
    input  mode, in_valid, data_in, out_ready,
    output in_ready, out_valid, data_out, out_last
  );

endinterface

// File: rtl/pool_stream_array.sv
// ---------------------------------------------------------------------------
// pool_stream_array
//   2x2 / stride-2 pooling over a row-major pixel stream, array_size channels
//   in lockstep. Max or average mode is chosen at the first pixel of every
//   frame. Each channel keeps a half-row line buffer holding the combined top
//   pair of every window, so the window result is ready as soon as the
//   bottom-right pixel arrives and is registered with one clock of latency.
//
//   Ports
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     clear  synchronous frame abort (everything but the line buffer)
//     busy   frame in progress: first pixel taken, last result not yet taken
//     bus    pool_stream_if.slave: pixel input, result output, mode select
// ---------------------------------------------------------------------------
module pool_stream_array #(
  parameter int data_size  = 16,
  parameter int array_size = 9,
  parameter int img_width  = 8,
  parameter int img_height = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  output logic         busy,
  pool_stream_if.slave bus
);

  localparam int half_w = img_width / 2;
  localparam int cw     = (img_width  > 1) ? $clog2(img_width)  : 1;
  localparam int rw     = (img_height > 1) ? $clog2(img_height) : 1;
  localparam int aw     = (half_w     > 1) ? $clog2(half_w)     : 1;

  localparam logic [cw-1:0] col_last = cw'(img_width - 1);
  localparam logic [rw-1:0] row_last = rw'(img_height - 1);

  typedef logic [data_size-1:0] pix_t;
  typedef logic [data_size:0]   pair_t;   // one extra bit so a pair sum cannot overflow

  // Combine two pixels: signed max (sign-extended) or exact sum.
  function automatic pair_t pair_fn(input pix_t x, input pix_t y, input logic avg);
    logic signed [data_size:0] xs;
    logic signed [data_size:0] ys;
    xs = $signed({x[data_size-1], x});
    ys = $signed({y[data_size-1], y});
    if (avg) return pair_t'(xs + ys);
    return (xs > ys) ? pair_t'(xs) : pair_t'(ys);
  endfunction

  // Combine the two pairs of a window. The average is the 4-sum shifted
  // arithmetically by 2 (floor), which always fits back into data_size bits;
  // a max of sign-extended pixels likewise drops only a copy of the sign.
  function automatic pix_t quad_fn(input pair_t p, input pair_t q, input logic avg);
    logic signed [data_size+1:0] sum4;
    logic signed [data_size:0]   ps;
    logic signed [data_size:0]   qs;
    ps   = $signed(p);
    qs   = $signed(q);
    sum4 = $signed({p[data_size], p}) + $signed({q[data_size], q});
    if (avg) return pix_t'(sum4 >>> 2);
    return (ps > qs) ? pix_t'(ps) : pix_t'(qs);
  endfunction

  // State
  logic [cw-1:0]                      col_q, col_d;
  logic [rw-1:0]                      row_q, row_d;
  logic                               mode_q, mode_d;
  logic [array_size-1:0][data_size-1:0] a_q, a_d;
  logic [array_size-1:0][data_size-1:0] b_q, b_d;
  logic [array_size-1:0][data_size-1:0] data_out_q, data_out_d;
  logic                               out_valid_q, out_valid_d;
  logic                               out_last_q, out_last_d;
  logic                               busy_q, busy_d;

  // Line buffer: one combined top pair per window column
  logic [array_size-1:0][data_size:0] lb_mem [half_w];
  logic [array_size-1:0][data_size:0] lb_rd;
  logic [array_size-1:0][data_size:0] lb_wdata;
  logic [aw-1:0]                      lb_addr;
  logic                               lb_we;

  // Datapath
  logic [array_size-1:0][data_size:0]   pair_top;
  logic [array_size-1:0][data_size:0]   pair_bot;
  logic [array_size-1:0][data_size-1:0] quad;

  logic in_fire;
  logic out_fire;

  assign bus.in_ready  = !out_valid_q || bus.out_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.data_out  = data_out_q;
  assign busy          = busy_q;

  assign in_fire  = bus.in_valid && bus.in_ready;
  assign out_fire = out_valid_q && bus.out_ready;

  assign lb_addr = aw'(col_q >> 1);
  assign lb_rd   = lb_mem[lb_addr];

  // Every combine uses the latched frame mode; no combine happens on the
  // first pixel of a frame, so mode_q is always valid when it is needed.
  always_comb begin
    for (int i = 0; i < array_size; i++) begin
      pair_top[i] = pair_fn(a_q[i], bus.data_in[i*data_size +: data_size], mode_q);
      pair_bot[i] = pair_fn(b_q[i], bus.data_in[i*data_size +: data_size], mode_q);
      quad[i]     = quad_fn(lb_rd[i], pair_bot[i], mode_q);
    end
  end

  // NOTE: every signal assigned here gets its hold value first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    mode_d      = mode_q;
    a_d         = a_q;
    b_d         = b_q;
    data_out_d  = data_out_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
    lb_we       = 1'b0;
    lb_wdata    = pair_top;

    if (clear) begin
      col_d       = '0;
      row_d       = '0;
      mode_d      = 1'b0;
      a_d         = '0;
      b_d         = '0;
      data_out_d  = '0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      busy_d      = 1'b0;
    end else begin
      if (out_fire) begin
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        if (out_last_q) busy_d = 1'b0;
      end

      if (in_fire) begin
        // Frame start wins over the last-output clear so busy stays high
        // across back-to-back frames.
        if (col_q == '0 && row_q == '0) begin
          mode_d = bus.mode;
          busy_d = 1'b1;
        end

        unique case ({row_q[0], col_q[0]})
          2'b00: a_d   = bus.data_in;
          2'b01: lb_we = 1'b1;
          2'b10: b_d   = bus.data_in;
          default: begin
            // A completing window overrides an output taken this cycle.
            data_out_d  = quad;
            out_valid_d = 1'b1;
            out_last_d  = (row_q == row_last) && (col_q == col_last);
          end
        endcase

        if (col_q == col_last) begin
          col_d = '0;
          row_d = (row_q == row_last) ? '0 : row_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before the edge regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      mode_q      <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      mode_q      <= mode_d;
      a_q         <= a_d;
      b_q         <= b_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
    end
  end

  // NOTE: the line buffer has no reset; each entry is written on the top row
  // of a window pair before the bottom row reads it, so stale contents are
  // never observed and the array can map to plain storage.
  always_ff @(posedge clk) begin
    if (lb_we) lb_mem[lb_addr] <= lb_wdata;
  end

endmodule

// File: tb/tb_pool_stream_array.sv
// ---------------------------------------------------------------------------
// tb_pool_stream_array
//   Directed + randomized bench for pool_stream_array on a 4x4 frame with
//   9 channels. Frames are generated here, expected pooled windows are
//   computed from the whole frame with integer arithmetic, and a scoreboard
//   matches every output transfer in order.
// ---------------------------------------------------------------------------
module tb_pool_stream_array;

  localparam int ds  = 16;
  localparam int nch = 9;
  localparam int W   = 4;
  localparam int H   = 4;
  localparam int dw  = ds * nch;

  logic clk = 1'b0;
  logic rst_n;
  logic clear;
  logic busy;

  pool_stream_if #(.data_size(ds), .array_size(nch)) bus_if ();

  pool_stream_array #(
    .data_size (ds),
    .array_size(nch),
    .img_width (W),
    .img_height(H)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(clear),
    .busy (busy),
    .bus  (bus_if)
  );

  always #5 clk = ~clk;

  // Input beats and scoreboard
  logic [dw-1:0] in_q[$];
  logic          mode_in_q[$];
  logic          first_q[$];
  logic [dw-1:0] exp_q[$];
  logic          exp_last_q[$];
  logic [ds-1:0] obs0[$];
  logic [ds-1:0] obs1[$];

  int   n_checks = 0;
  int   n_fail   = 0;
  int   frames_open = 0;
  int   outs     = 0;
  int   stalls   = 0;
  int   ready_mode = 0;   // 0: always ready, 1: random, 2: never ready
  bit   rand_gaps  = 1'b0;
  bit   hold_valid = 1'b0;
  logic [dw-1:0] held_data;
  logic          held_last;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Build one frame, queue nb of its beats, and optionally its expected
  // windows. kind: 0 random, 1 ch0 ramp, 2 avg corner window, 3 all nines.
  task automatic push_frame(input int nb, input bit gen_exp, input logic m_first,
                            input logic m_rest, input int kind);
    logic [dw-1:0] px [W*H];
    logic [dw-1:0] e;
    logic [ds-1:0] v;
    int r, c, idx, res, s, mx;
    int vals [4];
    for (int p = 0; p < W*H; p++) begin
      r = p / W;
      c = p % W;
      for (int ch = 0; ch < nch; ch++) begin
        v = ds'($urandom);
        case (kind)
          1: if (ch == 0) v = ds'(p);
          2: if (r < 2 && c < 2) begin
               if (ch == 0) v = ds'(-(r*2 + c + 1));
               if (ch == 1) v = ds'(32767);
             end
          3: v = ds'(9);
          default: ;
        endcase
        px[p][ch*ds +: ds] = v;
      end
    end
    for (int p = 0; p < nb; p++) begin
      in_q.push_back(px[p]);
      mode_in_q.push_back((p == 0) ? m_first : m_rest);
      first_q.push_back(p == 0);
    end
    if (gen_exp) begin
      for (int wr = 0; wr < H/2; wr++) begin
        for (int wc = 0; wc < W/2; wc++) begin
          e = '0;
          for (int ch = 0; ch < nch; ch++) begin
            for (int k = 0; k < 4; k++) begin
              idx = (2*wr + k/2) * W + 2*wc + k%2;
              vals[k] = int'($signed(px[idx][ch*ds +: ds]));
            end
            if (!m_first) begin
              mx = vals[0];
              for (int k = 1; k < 4; k++) if (vals[k] > mx) mx = vals[k];
              res = mx;
            end else begin
              s   = vals[0] + vals[1] + vals[2] + vals[3];
              res = s / 4;
              if (s < 0 && (s % 4) != 0) res = res - 1;
            end
            e[ch*ds +: ds] = ds'(res);
          end
          exp_q.push_back(e);
          exp_last_q.push_back(wr == H/2-1 && wc == W/2-1);
        end
      end
    end
  endtask

  // One clock: drive, check, advance. Entered and left at posedge + 1.
  task automatic tick();
    logic fire_in, fire_out;
    bus_if.in_valid  = (in_q.size() > 0) && (!rand_gaps || $urandom_range(3) != 0);
    bus_if.data_in   = (in_q.size() > 0) ? in_q[0] : '0;
    bus_if.mode      = (in_q.size() > 0) ? mode_in_q[0] : 1'b0;
    case (ready_mode)
      0:       bus_if.out_ready = 1'b1;
      1:       bus_if.out_ready = 1'($urandom_range(1));
      default: bus_if.out_ready = 1'b0;
    endcase
    #1;
    check("busy", busy, frames_open > 0);
    if (hold_valid) begin
      check("bp_data_stable", bus_if.data_out, held_data);
      check("bp_last_stable", bus_if.out_last, held_last);
    end
    if (bus_if.out_ready) check("in_ready_free", bus_if.in_ready, 1'b1);
    else if (bus_if.out_valid) check("in_ready_bp", bus_if.in_ready, 1'b0);

    fire_in  = bus_if.in_valid && bus_if.in_ready;
    fire_out = bus_if.out_valid && bus_if.out_ready;
    if (bus_if.in_valid && !bus_if.in_ready) stalls++;

    if (fire_out) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", bus_if.out_valid, 1'b0);
      end else begin
        check("data_out", bus_if.data_out, exp_q[0]);
        check("out_last", bus_if.out_last, exp_last_q[0]);
        obs0.push_back(bus_if.data_out[0 +: ds]);
        obs1.push_back(bus_if.data_out[ds +: ds]);
        if (exp_last_q[0]) frames_open--;
        void'(exp_q.pop_front());
        void'(exp_last_q.pop_front());
        outs++;
      end
    end
    hold_valid = bus_if.out_valid && !bus_if.out_ready;
    held_data  = bus_if.data_out;
    held_last  = bus_if.out_last;
    if (fire_in) begin
      if (first_q[0]) frames_open++;
      void'(in_q.pop_front());
      void'(mode_in_q.pop_front());
      void'(first_q.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget, input string tag);
    int n = 0;
    while ((in_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_timeout"}, n < budget, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  int t1_exp [4] = '{5, 7, 13, 15};
  int n;
  int sz;

  initial begin
    rst_n            = 1'b0;
    clear            = 1'b0;
    bus_if.in_valid  = 1'b0;
    bus_if.data_in   = '0;
    bus_if.mode      = 1'b0;
    bus_if.out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", bus_if.out_valid, 1'b0);
    check("rst_out_last",  bus_if.out_last,  1'b0);
    check("rst_busy",      busy,             1'b0);
    check("rst_data_out",  bus_if.data_out,  '0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready",  bus_if.in_ready,  1'b1);
    @(posedge clk);
    #1;

    // 1: max, ch0 ramp 0..15
    obs0.delete(); obs1.delete(); outs = 0;
    ready_mode = 0; rand_gaps = 1'b0;
    push_frame(16, 1'b1, 1'b0, 1'b0, 1);
    drain(200, "t1");
    check("t1_busy_after", busy, 1'b0);
    check("t1_count", obs0.size(), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("t1_ch0_%0d", i), (i < obs0.size()) ? obs0[i] : '1, ds'(t1_exp[i]));
    idle(3);

    // 2: average with negative floor and positive saturation edge
    obs0.delete(); obs1.delete();
    push_frame(16, 1'b1, 1'b1, 1'b1, 2);
    drain(200, "t2");
    check("t2_ch0_floor", (obs0.size() > 0) ? obs0[0] : '0, 16'hFFFD);
    check("t2_ch1_max",   (obs1.size() > 0) ? obs1[0] : '0, 16'h7FFF);
    idle(2);

    // 3: backpressure for 5 cycles after the first result
    outs = 0;
    push_frame(16, 1'b1, 1'b0, 1'b0, 0);
    n = 0;
    while (!bus_if.out_valid && n < 100) begin
      tick();
      n++;
    end
    check("t3_first_timeout", n < 100, 1'b1);
    ready_mode = 2;
    sz = in_q.size();
    repeat (5) tick();
    check("t3_no_advance", in_q.size(), sz);
    ready_mode = 0;
    drain(200, "t3");
    check("t3_count", outs, 4);
    idle(2);

    // 4: mode toggled mid-frame, then an average frame
    outs = 0;
    push_frame(16, 1'b1, 1'b0, 1'b1, 0);
    push_frame(16, 1'b1, 1'b1, 1'b1, 0);
    drain(400, "t4");
    check("t4_count", outs, 8);
    idle(2);

    // 5: clear after 6 pixels with a result pending, then an all-nines frame
    ready_mode = 2;
    push_frame(6, 1'b0, 1'b0, 1'b0, 0);
    n = 0;
    while (in_q.size() > 0 && n < 100) begin
      tick();
      n++;
    end
    check("t5_partial_timeout", n < 100, 1'b1);
    bus_if.in_valid = 1'b0;
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    frames_open = 0;
    hold_valid  = 1'b0;
    check("t5_clr_out_valid", bus_if.out_valid, 1'b0);
    check("t5_clr_busy",      busy,             1'b0);
    check("t5_clr_out_last",  bus_if.out_last,  1'b0);
    obs0.delete(); outs = 0; ready_mode = 0;
    push_frame(16, 1'b1, 1'b0, 1'b0, 3);
    drain(200, "t5");
    idle(3);
    check("t5_count", outs, 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("t5_ch0_%0d", i), (i < obs0.size()) ? obs0[i] : '0, 16'd9);

    // 6: back-to-back frames, no stalls
    outs = 0; stalls = 0;
    push_frame(16, 1'b1, 1'($urandom_range(1)), 1'b0, 0);
    push_frame(16, 1'b1, 1'($urandom_range(1)), 1'b1, 0);
    n = 0;
    while (in_q.size() > 0 && n < 100) begin
      tick();
      n++;
    end
    check("t6_cycles", n, 32);
    drain(100, "t6");
    check("t6_count",  outs,   8);
    check("t6_stalls", stalls, 0);
    idle(2);

    // 7: random frames, random gaps and backpressure
    outs = 0; rand_gaps = 1'b1; ready_mode = 1;
    for (int f = 0; f < 4; f++)
      push_frame(16, 1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)), 0);
    drain(3000, "t7");
    idle(4);
    check("t7_count", outs, 16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
